comparators: RTL and testbench

Registered magnitude/equality comparator for two WIDTH-bit operands, producing all six relational flags (eq, neq, lt, lte, gt, gte) in one clock. Sits in the datapath next to the ALU and feeds branch-condition and set-on-compare logic. Operands are unsigned by default; signed (two's-complement) comparison is a compile-time option.

---
 rtl/comparators_pkg.sv | 22 ++
 rtl/comparators_core.sv | 31 +++
 rtl/comparators.sv | 51 +++++
 tb/tb_comparators.sv | 137 +++++++++++++
 4 files changed

// File: rtl/comparators_pkg.sv
// comparators_pkg: flag bit indices, flag vector type and flag derivation shared with branch logic.
package comparators_pkg;
  localparam int FLAG_EQ  = 0;
  localparam int FLAG_NEQ = 1;
  localparam int FLAG_LT  = 2;
  localparam int FLAG_LTE = 3;
  localparam int FLAG_GT  = 4;
  localparam int FLAG_GTE = 5;
  localparam int FLAG_N   = 6;
  typedef logic [FLAG_N-1:0] flags_t;
  // All six relations follow from equality and less-than alone.
  function automatic flags_t derive_flags(input logic e, input logic l);
    flags_t f;
    f[FLAG_EQ]  = e;
    f[FLAG_NEQ] = ~e;
    f[FLAG_LT]  = l;
    f[FLAG_LTE] = l | e;
    f[FLAG_GT]  = ~(l | e);
    f[FLAG_GTE] = ~l;
    return f;
  endfunction
endpackage

// File: rtl/comparators_core.sv
// comparators_core: combinational equality and less-than primitives; signed ordering with COMPARATORS_SIGNED_EN.
module comparators_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef COMPARATORS_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             e,
  output logic             l
);
  logic [WIDTH-1:0] xm;
  logic [WIDTH-1:0] ym;
`ifdef COMPARATORS_SIGNED_EN
  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    xm = x ^ {sgn, {(WIDTH-1){1'b0}}};
    ym = y ^ {sgn, {(WIDTH-1){1'b0}}};
  end
`else
  always_comb begin
    xm = x;
    ym = y;
  end
`endif
  always_comb begin
    e = xm == ym;
    l = xm < ym;
  end
endmodule

// File: rtl/comparators.sv
// comparators: registered six-flag comparator, one-cycle latency; signed mode via COMPARATORS_SIGNED_EN.
module comparators
  import comparators_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef COMPARATORS_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  output logic             eq,
  output logic             neq,
  output logic             lt,
  output logic             lte,
  output logic             gt,
  output logic             gte
);
  logic   e;
  logic   l;
  flags_t flags_q;
  comparators_core #(.WIDTH(WIDTH)) u_core (
    .x(x),
    .y(y),
`ifdef COMPARATORS_SIGNED_EN
    .sgn(sgn),
`endif
    .e(e),
    .l(l)
  );
  // Flags hold their last value while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      flags_q   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) flags_q <= derive_flags(e, l);
    end
  end
  assign eq  = flags_q[FLAG_EQ];
  assign neq = flags_q[FLAG_NEQ];
  assign lt  = flags_q[FLAG_LT];
  assign lte = flags_q[FLAG_LTE];
  assign gt  = flags_q[FLAG_GT];
  assign gte = flags_q[FLAG_GTE];
endmodule

// File: tb/tb_comparators.sv
// tb_comparators: table-driven directed checks of comparators plus reset/hold sequences.
module tb_comparators;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
`ifdef COMPARATORS_SIGNED_EN
  logic       sgn = 1'b0;
`endif
  logic out_valid, eq, neq, lt, lte, gt, gte;
  int total = 0;
  int bad = 0;
  localparam logic [5:0] F_EQ = 6'b101001;
  localparam logic [5:0] F_LT = 6'b001110;
  localparam logic [5:0] F_GT = 6'b110010;
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       s;
    logic [5:0] f;
  } vec_t;
  vec_t vecs[16];
  int nv;
  logic [5:0] last_f;

  comparators #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .x(x),
    .y(y),
`ifdef COMPARATORS_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(out_valid),
    .eq(eq),
    .neq(neq),
    .lt(lt),
    .lte(lte),
    .gt(gt),
    .gte(gte)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {out_valid, gte, gt, lte, lt, neq, eq};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {v,gte,gt,lte,lt,neq,eq}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [5:0] f);
    vecs[nv] = '{x: a, y: b, s: s, f: f};
    nv++;
  endtask

  initial begin
    nv = 0;
    add(8'h00, 8'h00, 1'b0, F_EQ);
    add(8'h81, 8'h08, 1'b0, F_GT);
    add(8'h01, 8'h02, 1'b0, F_LT);
    add(8'hFF, 8'hFF, 1'b0, F_EQ);
    add(8'h00, 8'hFF, 1'b0, F_LT);
    add(8'hFF, 8'h00, 1'b0, F_GT);
    add(8'h7F, 8'h80, 1'b0, F_LT);
    add(8'h80, 8'h7F, 1'b0, F_GT);
    add(8'h01, 8'h00, 1'b0, F_GT);
    add(8'h55, 8'h55, 1'b0, F_EQ);
`ifdef COMPARATORS_SIGNED_EN
    add(8'h81, 8'h08, 1'b1, F_LT);
    add(8'h7F, 8'h80, 1'b1, F_GT);
    add(8'hFF, 8'h00, 1'b1, F_LT);
    add(8'h80, 8'h80, 1'b1, F_EQ);
    add(8'h80, 8'hFF, 1'b1, F_LT);
`endif
    // reset held with valid operands present: outputs stay clear
    in_valid = 1'b1;
    x = 8'd5;
    y = 8'd5;
    repeat (2) @(negedge clk);
    check("reset_hold", 7'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_after_reset", {1'b1, F_EQ});
    // table vectors back-to-back
    for (int i = 0; i < nv; i++) begin
      x = vecs[i].x;
      y = vecs[i].y;
`ifdef COMPARATORS_SIGNED_EN
      sgn = vecs[i].s;
`endif
      @(negedge clk);
      check($sformatf("vec%0d_%h_%h", i, vecs[i].x, vecs[i].y), {1'b1, vecs[i].f});
    end
`ifdef COMPARATORS_SIGNED_EN
    sgn = 1'b0;
`endif
    // back-to-back lt then eq, then idle holds flags
    x = 8'h01; y = 8'h02;
    @(negedge clk);
    check("b2b_lt", {1'b1, F_LT});
    x = 8'hFF; y = 8'hFF;
    @(negedge clk);
    check("b2b_eq", {1'b1, F_EQ});
    in_valid = 1'b0;
    x = 8'h00; y = 8'h10;
    @(negedge clk);
    check("idle_hold", {1'b0, F_EQ});
    @(negedge clk);
    check("idle_hold2", {1'b0, F_EQ});
    // async reset mid-stream, between edges
    in_valid = 1'b1;
    x = 8'h20; y = 8'h10;
    @(negedge clk);
    check("pre_async", {1'b1, F_GT});
    #2 rst_n = 1'b0;
    #1 check("async_clear", 7'b0);
    #1 rst_n = 1'b1;
    last_f = F_LT;
    x = 8'h10; y = 8'h20;
    @(negedge clk);
    check("post_async", {1'b1, last_f});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
